key_search_ctrl: RTL and testbench

KEY_SEARCH_CTRL -- requirements
Module: key_search_ctrl

---
 rtl/rc4_pkg.sv | 17 +
 rtl/key_counter.sv | 37 +++
 rtl/key_search_ctrl.sv | 160 ++++++++++++++++
 tb/tb_key_search_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared widths, search limit and search-state encoding for the RC4 key search slice.
package rc4_pkg;

  localparam int unsigned          KEY_WIDTH = 24;
  localparam logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT      = 3'd2,
    S_CHECK     = 3'd3,
    S_NEXT      = 3'd4,
    S_FOUND     = 3'd5,
    S_EXHAUSTED = 3'd6
  } search_state_e;

endpackage

// File: rtl/key_counter.sv
// Candidate key register: loadable, increments by one and saturates at MAX.
module key_counter #(
  parameter int unsigned      WIDTH = 24,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_max_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && (count_q != MAX)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign at_max_o = (count_q == MAX);

endmodule

// File: rtl/key_search_ctrl.sv
// Drives an RC4 core through brute-force or manual single-key attempts and
// latches the first key whose decryption is reported as valid.
module key_search_ctrl #(
  parameter int unsigned          KEY_WIDTH = rc4_pkg::KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX   = rc4_pkg::KEY_MAX,
  parameter int unsigned          SW_WIDTH  = 10
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [SW_WIDTH-1:0]  sw_key,
  input  logic                 sw_key_available,
  input  logic                 sw_key_changed,
  input  logic                 mode_auto,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 core_ready,
  output logic                 core_start,
  output logic [KEY_WIDTH-1:0] core_key,
  input  logic                 core_done,
  input  logic                 core_key_valid,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic [KEY_WIDTH-1:0] found_key
);

  import rc4_pkg::*;

  search_state_e        state_q, state_d;
  logic                 found_q, found_d;
  logic                 exh_q, exh_d;
  logic [KEY_WIDTH-1:0] fkey_q, fkey_d;
  logic                 pend_q, pend_d;
  logic                 auto_q, auto_d;
  logic                 valid_q, valid_d;

  logic                 cnt_load, cnt_inc, cnt_at_max, launch;
  logic [KEY_WIDTH-1:0] cnt_load_val;
  logic                 manual_req;

  key_counter #(
    .WIDTH (KEY_WIDTH),
    .MAX   (KEY_MAX)
  ) u_key_counter (
    .clk_i      (CLOCK_50),
    .rst_i      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .inc_i      (cnt_inc),
    .count_o    (core_key),
    .at_max_o   (cnt_at_max)
  );

  assign manual_req = !mode_auto && sw_key_changed && sw_key_available;
  assign busy = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                (state_q == S_CHECK)  || (state_q == S_NEXT);

  always_comb begin
    state_d      = state_q;
    found_d      = found_q;
    exh_d        = exh_q;
    fkey_d       = fkey_q;
    pend_d       = pend_q;
    auto_d       = auto_q;
    valid_d      = valid_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_inc      = 1'b0;
    launch       = 1'b0;

    // A manual key change mid-attempt is replayed once the attempt resolves.
    if (busy && manual_req) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_FOUND, S_EXHAUSTED: begin
        if (mode_auto && start) begin
          cnt_load     = 1'b1;
          cnt_load_val = '0;
          auto_d       = 1'b1;
          found_d      = 1'b0;
          exh_d        = 1'b0;
          pend_d       = 1'b0;
          state_d      = S_LAUNCH;
        end else if (!mode_auto && (manual_req || pend_q)) begin
          cnt_load     = 1'b1;
          cnt_load_val = KEY_WIDTH'(sw_key);
          auto_d       = 1'b0;
          found_d      = 1'b0;
          exh_d        = 1'b0;
          pend_d       = 1'b0;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (core_ready) begin
          launch  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_done) begin
          valid_d = core_key_valid;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (valid_q) begin
          found_d = 1'b1;
          fkey_d  = core_key;
          state_d = S_FOUND;
        end else if (!auto_q) begin
          state_d = S_IDLE;
        end else if (cnt_at_max) begin
          exh_d   = 1'b1;
          state_d = S_EXHAUSTED;
        end else if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        cnt_inc = 1'b1;
        state_d = S_LAUNCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign core_start = launch && !reset;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      found_q <= 1'b0;
      exh_q   <= 1'b0;
      fkey_q  <= '0;
      pend_q  <= 1'b0;
      auto_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      found_q <= found_d;
      exh_q   <= exh_d;
      fkey_q  <= fkey_d;
      pend_q  <= pend_d;
      auto_q  <= auto_d;
      valid_q <= valid_d;
    end
  end

  assign found     = found_q;
  assign exhausted = exh_q;
  assign found_key = fkey_q;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed and randomized checks of key_search_ctrl against a behavioural RC4 core model.
`timescale 1ns/1ps
module tb_key_search_ctrl;

  localparam int unsigned     KW   = 24;
  localparam int unsigned     SWW  = 10;
  localparam logic [KW-1:0]   KMAX = 24'h00000F;

  logic            CLOCK_50 = 1'b0;
  logic            reset;
  logic [SWW-1:0]  sw_key;
  logic            sw_key_available, sw_key_changed, mode_auto, start, abort;
  logic            core_ready, core_start, core_done, core_key_valid;
  logic [KW-1:0]   core_key;
  logic            busy, found, exhausted;
  logic [KW-1:0]   found_key;

  key_search_ctrl #(
    .KEY_WIDTH (KW),
    .KEY_MAX   (KMAX),
    .SW_WIDTH  (SWW)
  ) dut (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .sw_key           (sw_key),
    .sw_key_available (sw_key_available),
    .sw_key_changed   (sw_key_changed),
    .mode_auto        (mode_auto),
    .start            (start),
    .abort            (abort),
    .core_ready       (core_ready),
    .core_start       (core_start),
    .core_key         (core_key),
    .core_done        (core_done),
    .core_key_valid   (core_key_valid),
    .busy             (busy),
    .found            (found),
    .exhausted        (exhausted),
    .found_key        (found_key)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int            checks = 0;
  int            errors = 0;
  logic [KW-1:0] launches[$];
  logic [KW-1:0] target = '1;
  int            lat_min = 0, lat_max = 3, gap_max = 2, ready_block = 0;
  bit            running = 1'b0;
  int            cnt = 0;
  logic [KW-1:0] run_key = '0;
  bit            saw_2a5 = 1'b0;

  // Core model: accepts a launch, runs a random number of cycles, reports
  // valid only for the target key. It keeps running across a controller reset.
  initial begin : core_model
    core_ready = 1'b0; core_done = 1'b0; core_key_valid = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      core_done = 1'b0; core_key_valid = 1'b0;
      if (running) begin
        if (cnt == 0) begin
          core_done      = 1'b1;
          core_key_valid = (run_key == target);
          running        = 1'b0;
          ready_block    = $urandom_range(0, gap_max);
        end else cnt--;
      end else if (ready_block > 0) ready_block--;
      core_ready = !running && (ready_block == 0);
      #1;
      if (core_start) begin
        launches.push_back(core_key);
        running = 1'b1;
        run_key = core_key;
        cnt     = $urandom_range(lat_min, lat_max);
      end
      if (found && found_key == 24'h0002A5) saw_2a5 = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge CLOCK_50);
      n++;
      if (!busy && !running) quiet++; else quiet = 0;
    end
    check({tag, "_quiet"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_launches(input string tag, input int num, input int budget);
    int n = 0;
    while (launches.size() < num && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    check({tag, "_launched"}, 32'(n < budget), 32'd1);
  endtask

  // Reference: an auto search launches keys 0,1,2,... up to the target or KEY_MAX.
  task automatic check_auto(input string tag, input logic [KW-1:0] t);
    int unsigned n;
    bit          seq_ok;
    n = (t <= KMAX) ? 32'(t) + 1 : 32'(KMAX) + 1;
    seq_ok = (launches.size() == n);
    for (int i = 0; i < launches.size(); i++)
      if (launches[i] !== KW'(i)) seq_ok = 1'b0;
    check({tag, "_nlaunch"}, launches.size(), n);
    check({tag, "_seq"}, 32'(seq_ok), 32'd1);
    check({tag, "_found"}, 32'(found), 32'(t <= KMAX));
    check({tag, "_exhausted"}, 32'(exhausted), 32'(t > KMAX));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    if (t <= KMAX) check({tag, "_found_key"}, found_key, t);
  endtask

  initial begin : stimulus
    logic [KW-1:0] t;
    reset = 1'b1; sw_key = '0; sw_key_available = 1'b0; sw_key_changed = 1'b0;
    mode_auto = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_busy", 32'(busy), 0);
    check("rst_found", 32'(found), 0);
    check("rst_exhausted", 32'(exhausted), 0);
    check("rst_found_key", found_key, 0);
    check("rst_core_key", core_key, 0);
    check("rst_core_start", 32'(core_start), 0);
    reset = 1'b0;
    @(negedge CLOCK_50);

    // Auto search finds key 5
    mode_auto = 1'b1; target = 24'h000005; launches.delete();
    pulse_start();
    wait_quiet("auto5", 300);
    check_auto("auto5", 24'h000005);

    // Launch held off while the core is not ready
    t = KW'($urandom_range(1, 14)); target = t; launches.delete();
    ready_block = 8;
    @(negedge CLOCK_50);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      check("hold_busy", 32'(busy), 1);
      check("hold_nolaunch", launches.size(), 0);
      check("hold_core_key", core_key, 0);
      @(negedge CLOCK_50);
    end
    wait_quiet("hold", 400);
    check_auto("hold", t);

    // Exhaustion at KEY_MAX with no valid key
    target = '1; launches.delete();
    pulse_start();
    wait_quiet("exh", 600);
    check_auto("exh", '1);
    repeat (10) @(negedge CLOCK_50);
    check("exh_no_extra", launches.size(), 32'(KMAX) + 1);

    // Manual attempt, second key change arrives mid-attempt
    mode_auto = 1'b0; target = 24'h0002A5; launches.delete(); saw_2a5 = 1'b0;
    sw_key = 10'h2A5; sw_key_available = 1'b1; sw_key_changed = 1'b1;
    @(negedge CLOCK_50);
    sw_key_changed = 1'b0;
    wait_launches("man", 1, 50);
    sw_key = 10'h13C; sw_key_changed = 1'b1;
    @(negedge CLOCK_50);
    sw_key_changed = 1'b0;
    wait_quiet("man", 200);
    check("man_nlaunch", launches.size(), 2);
    check("man_key0", launches[0], 24'h0002A5);
    check("man_key1", launches[1], 24'h00013C);
    check("man_saw_found", 32'(saw_2a5), 1);
    check("man_core_key", core_key, 24'h00013C);
    check("man_found_final", 32'(found), 0);

    // Abort while waiting on key 3; start mid-search is ignored
    mode_auto = 1'b1; target = '1; launches.delete();
    pulse_start();
    wait_launches("abort", 4, 100);
    abort = 1'b1; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    wait_quiet("abort", 100);
    abort = 1'b0;
    repeat (6) @(negedge CLOCK_50);
    check("abort_nlaunch", launches.size(), 4);
    check("abort_last", launches[3], 24'h000003);
    check("abort_found", 32'(found), 0);
    check("abort_exhausted", 32'(exhausted), 0);
    check("abort_busy", 32'(busy), 0);

    // Randomized auto searches
    for (int r = 0; r < 5; r++) begin
      t = KW'($urandom_range(0, 18)); target = t; launches.delete();
      lat_max = $urandom_range(0, 5);
      pulse_start();
      wait_quiet("rand", 800);
      check_auto("rand", t);
    end

    // Reset while waiting on key 2; the late valid done must be ignored
    lat_min = 5; lat_max = 5; target = 24'h000002; launches.delete();
    pulse_start();
    wait_launches("rstw", 3, 100);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("rstw_busy", 32'(busy), 0);
    check("rstw_found", 32'(found), 0);
    check("rstw_exhausted", 32'(exhausted), 0);
    check("rstw_found_key", found_key, 0);
    check("rstw_core_key", core_key, 0);
    check("rstw_core_start", 32'(core_start), 0);
    reset = 1'b0;
    wait_quiet("rstw", 100);
    check("rstw_late_found", 32'(found), 0);
    check("rstw_late_busy", 32'(busy), 0);
    check("rstw_nlaunch", launches.size(), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
